// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam int PC_STEP = 4;
  localparam logic REDIR_BRANCH = 1'b0;
  localparam logic REDIR_JUMP = 1'b1;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: redirect target (branch relative to instr_pc+4, jump absolute); PC_ALIGN_CHECK_EN forces word alignment
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                redirect_kind,
  input  logic [PC_WIDTH-1:0] redirect_offset,
  output logic [PC_WIDTH-1:0] target
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                misaligned
`endif
);
  logic [PC_WIDTH-1:0] raw;
  assign raw = redirect_kind == REDIR_JUMP ? redirect_offset
             : instr_pc + PC_WIDTH'(PC_STEP) + (redirect_offset << 2);
`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |raw[1:0];
  assign target = {raw[PC_WIDTH-1:2], 2'b00};
`else
  assign target = raw;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC and IDLE/FETCH/HOLD fetch FSM with redirects; PC_ALIGN_CHECK_EN adds misalign_err
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic                   redirect_kind,
  input  logic [PC_WIDTH-1:0]    redirect_offset,
  output logic [PC_WIDTH-1:0]    pc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   misalign_err
`endif
);
  state_t state, state_n;
  logic [PC_WIDTH-1:0] target;
  logic take;
  assign imem_req = state == FETCH;
  assign instr_valid = state == HOLD;
  assign imem_addr = pc;
  assign take = imem_req && imem_ack;
`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  pc_target_calc #(.PC_WIDTH(PC_WIDTH)) u_calc (
    .instr_pc(instr_pc), .redirect_kind(redirect_kind), .redirect_offset(redirect_offset),
    .target(target), .misaligned(misaligned)
  );
  // one-cycle flag for a redirect whose target had to be realigned
  always_ff @(posedge clk)
    misalign_err <= rst ? 1'b0 : redirect_valid && misaligned;
`else
  pc_target_calc #(.PC_WIDTH(PC_WIDTH)) u_calc (
    .instr_pc(instr_pc), .redirect_kind(redirect_kind), .redirect_offset(redirect_offset),
    .target(target)
  );
`endif
  // next state: IDLE always moves on, redirect beats ack/ready elsewhere
  always_comb begin
    state_n = state == IDLE                ? FETCH
            : redirect_valid               ? IDLE
            : take                         ? HOLD
            : state == HOLD && instr_ready ? FETCH
            : state;
  end
  // state, PC and fetched-instruction registers; an ack coinciding with a redirect is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= PC_WIDTH'(RESET_PC);
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) pc <= target;
      else if (take) begin
        pc <= pc + PC_WIDTH'(PC_STEP);
        instr <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, corner sequences and randomized run against a behavioural model
module tb_pc_sequencer;
  logic clk = 0;
  logic rst, imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, redirect_kind;
  logic [7:0] imem_addr, instr_pc, redirect_offset, pc;
  logic [31:0] imem_rdata, instr;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign_err;
`endif
  int checks = 0, errors = 0;

  pc_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_offset(redirect_offset), .pc(pc)
`ifdef PC_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rv, kind;
    logic [7:0] off;
    logic ack, ready, e_req, e_valid;
    logic [7:0] e_pc, e_ipc;
  } vec_t;
  vec_t tbl[$];

  // reference model: fetch phase 0=idle 1=waiting for memory 2=holding an instruction
  int m_ph;
  logic [7:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic m_mis;

  task automatic model_step();
    logic [7:0] t;
    if (rst) begin
      m_pc = 0; m_ph = 0; m_instr = 0; m_ipc = 0; m_mis = 0;
      return;
    end
    t = redirect_kind ? redirect_offset : 8'(m_ipc + 4 + redirect_offset * 4);
    m_mis = 0;
`ifdef PC_ALIGN_CHECK_EN
    m_mis = redirect_valid && t[1:0] != 2'b00;
    t[1:0] = 2'b00;
`endif
    if (m_ph == 0) begin
      m_ph = 1;
      if (redirect_valid) m_pc = t;
    end else if (redirect_valid) begin
      m_pc = t; m_ph = 0;
    end else if (m_ph == 1 && imem_ack) begin
      m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 8'd4; m_ph = 2;
    end else if (m_ph == 2 && instr_ready) m_ph = 1;
  endtask

  initial begin
    logic [7:0] prev_pc;
    rst = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_kind = 0; redirect_offset = 0;
    tick(); tick();
    chk("reset_req", imem_req, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_pc", pc, 0);
    chk("reset_instr", instr, 0);
    chk("reset_ipc", instr_pc, 0);

    //                rv kind off    ack rdy req val pc     ipc
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 8'h04, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 0, 8'h04, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 8'h08, 8'h04});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 8'h08, 8'h04});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h08, 8'h04});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 8'h0C, 8'h08});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h0C, 8'h08});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 1, 8'h10, 8'h0C});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h10, 8'h0C});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 8'h14, 8'h10});
    tbl.push_back('{1, 0, 8'hFE, 0, 0, 0, 0, 8'h0C, 8'h10});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h0C, 8'h10});
    tbl.push_back('{1, 1, 8'h40, 0, 0, 0, 0, 8'h40, 8'h10});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h40, 8'h10});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 8'h44, 8'h40});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h44, 8'h40});
    tbl.push_back('{1, 1, 8'h20, 0, 0, 0, 0, 8'h20, 8'h40});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h20, 8'h40});
    tbl.push_back('{1, 1, 8'h80, 1, 1, 0, 0, 8'h80, 8'h40});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'h80, 8'h40});
    tbl.push_back('{1, 1, 8'hFC, 0, 0, 0, 0, 8'hFC, 8'h40});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'hFC, 8'h40});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 8'h00, 8'hFC});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 8'hFC});

    rst = 0;
    prev_pc = 0;
    foreach (tbl[i]) begin
      redirect_valid = tbl[i].rv; redirect_kind = tbl[i].kind; redirect_offset = tbl[i].off;
      imem_ack = tbl[i].ack; instr_ready = tbl[i].ready; imem_rdata = memw(prev_pc);
      tick();
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_pc);
      chk($sformatf("tbl%0d_ipc", i), instr_pc, tbl[i].e_ipc);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_instr", i), instr, memw(tbl[i].e_ipc));
      prev_pc = tbl[i].e_pc;
    end

    // reset mid-FETCH with ack high wins over the ack
    redirect_valid = 0; instr_ready = 0; imem_ack = 1; imem_rdata = memw(8'h00); rst = 1;
    tick();
    chk("rstfetch_pc", pc, 0);
    chk("rstfetch_req", imem_req, 0);
    chk("rstfetch_valid", instr_valid, 0);
    chk("rstfetch_instr", instr, 0);
    rst = 0; imem_ack = 0;
    tick();
    chk("rst_idle_to_fetch", imem_req, 1);

    // misaligned jump target
    redirect_valid = 1; redirect_kind = 1; redirect_offset = 8'h43;
    tick();
    redirect_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_pc", pc, 8'h40);
    chk("misalign_pulse", misalign_err, 1);
`else
    chk("jump_verbatim_pc", pc, 8'h43);
`endif
    tick();
    chk("misalign_req", imem_req, 1);
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_drop", misalign_err, 0);
`endif

    // randomized run against the model
    rst = 1;
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 99) == 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      redirect_kind = 1'($urandom);
      redirect_offset = 8'($urandom);
      imem_ack = 1'($urandom);
      instr_ready = 1'($urandom);
      imem_rdata = $urandom;
      model_step();
      tick();
      chk("rnd_req", imem_req, m_ph == 1);
      chk("rnd_valid", instr_valid, m_ph == 2);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_ipc", instr_pc, m_ipc);
      chk("rnd_instr", instr, m_instr);
`ifdef PC_ALIGN_CHECK_EN
      chk("rnd_mis", misalign_err, m_mis);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
